// File: rtl/bip_control_unit.sv
// BIP processor control unit (second generation).
// Fetches one instruction per FETCH/EXEC pair and waits in FETCH while program
// memory is not ready. It decodes the latched instruction into datapath strobes
// and resolves branches and jumps. HLT parks the core until Reset. A saturating
// cycle counter runs while the core is not halted.
module bip_control_unit #(
  parameter int INSTR_W  = 16,
  parameter int OPCODE_W = 5,
  parameter int ADDR_W   = 11,
  parameter int CNT_W    = 32
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic [INSTR_W-1:0]          Instruction,
  input  logic                        InstrValid,
  input  logic                        Zero,
  input  logic                        Neg,
  output logic [ADDR_W-1:0]           Addr,
  output logic [INSTR_W-OPCODE_W-1:0] Operand,
  output logic [1:0]                  SelA,
  output logic                        SelB,
  output logic                        Op,
  output logic                        WrAcc,
  output logic                        WrRam,
  output logic                        RdRam,
  output logic                        Halted,
  output logic                        IllegalOp,
  output logic [CNT_W-1:0]            CycleCount
);

  localparam int OPR_W = INSTR_W - OPCODE_W;

  localparam logic [OPCODE_W-1:0] OP_HLT  = OPCODE_W'(0);
  localparam logic [OPCODE_W-1:0] OP_STO  = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OP_LD   = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OP_LDI  = OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] OP_ADD  = OPCODE_W'(4);
  localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(5);
  localparam logic [OPCODE_W-1:0] OP_SUB  = OPCODE_W'(6);
  localparam logic [OPCODE_W-1:0] OP_SUBI = OPCODE_W'(7);
  localparam logic [OPCODE_W-1:0] OP_BEQ  = OPCODE_W'(8);
  localparam logic [OPCODE_W-1:0] OP_BNE  = OPCODE_W'(9);
  localparam logic [OPCODE_W-1:0] OP_BLT  = OPCODE_W'(10);
  localparam logic [OPCODE_W-1:0] OP_JMP  = OPCODE_W'(11);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [INSTR_W-1:0]  ir_q, ir_d;
  logic                ill_q, ill_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [OPCODE_W-1:0] opcode;
  logic [ADDR_W-1:0]   branch_off;
  logic [ADDR_W-1:0]   jump_tgt;
  logic [ADDR_W-1:0]   pc_inc;
  logic [ADDR_W-1:0]   pc_branch;

  assign opcode = ir_q[INSTR_W-1 -: OPCODE_W];

  // Branch offsets are signed and jump targets unsigned; both wrap mod 2^ADDR_W.
  generate
    if (OPR_W >= ADDR_W) begin : gen_wide_operand
      assign branch_off = ir_q[ADDR_W-1:0];
      assign jump_tgt   = ir_q[ADDR_W-1:0];
    end else begin : gen_narrow_operand
      assign branch_off = {{(ADDR_W-OPR_W){ir_q[OPR_W-1]}}, ir_q[OPR_W-1:0]};
      assign jump_tgt   = {{(ADDR_W-OPR_W){1'b0}}, ir_q[OPR_W-1:0]};
    end
  endgenerate

  assign pc_inc    = pc_q + ADDR_W'(1);
  assign pc_branch = pc_inc + branch_off;

  // State, program counter, instruction register, sticky flag and counter.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      ill_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      ill_q   <= ill_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic and EXEC-only strobe decode; strobes come straight from
  // registered state so they drop as soon as Reset clears the state register.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    ill_d   = ill_q;
    cnt_d   = cnt_q;
    SelA    = 2'b00;
    SelB    = 1'b0;
    Op      = 1'b0;
    WrAcc   = 1'b0;
    WrRam   = 1'b0;
    RdRam   = 1'b0;

    if (state_q != S_HALT && cnt_q != {CNT_W{1'b1}}) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    case (state_q)
      S_FETCH: begin
        if (InstrValid) begin
          ir_d    = Instruction;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_FETCH;
        pc_d    = pc_inc;
        case (opcode)
          OP_HLT: begin
            pc_d    = pc_q;
            state_d = S_HALT;
          end
          OP_STO:  WrRam = 1'b1;
          OP_LD: begin
            WrAcc = 1'b1;
            RdRam = 1'b1;
          end
          OP_LDI: begin
            SelA  = 2'b01;
            WrAcc = 1'b1;
          end
          OP_ADD: begin
            SelA  = 2'b10;
            WrAcc = 1'b1;
            RdRam = 1'b1;
          end
          OP_ADDI: begin
            SelA  = 2'b10;
            SelB  = 1'b1;
            WrAcc = 1'b1;
          end
          OP_SUB: begin
            SelA  = 2'b10;
            Op    = 1'b1;
            WrAcc = 1'b1;
            RdRam = 1'b1;
          end
          OP_SUBI: begin
            SelA  = 2'b10;
            SelB  = 1'b1;
            Op    = 1'b1;
            WrAcc = 1'b1;
          end
          OP_BEQ:  if (Zero)  pc_d = pc_branch;
          OP_BNE:  if (!Zero) pc_d = pc_branch;
          OP_BLT:  if (Neg)   pc_d = pc_branch;
          OP_JMP:  pc_d = jump_tgt;
          default: ill_d = 1'b1;
        endcase
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  assign Addr       = pc_q;
  assign Operand    = ir_q[OPR_W-1:0];
  assign Halted     = (state_q == S_HALT);
  assign IllegalOp  = ill_q;
  assign CycleCount = cnt_q;

endmodule
